// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL bit positions,
// reset values and the counter state encoding.
package apb_timer_pkg;

    localparam int unsigned TIMER_DW    = 32;
    localparam int unsigned TIMER_OFS_W = 12;
    localparam int unsigned CTRL_W      = 4;

    // Byte offsets within the 4 KB slave window
    localparam logic [TIMER_OFS_W-1:0] TIMER_CTRL_OFS    = 12'h000;
    localparam logic [TIMER_OFS_W-1:0] TIMER_VALUE_OFS   = 12'h004;
    localparam logic [TIMER_OFS_W-1:0] TIMER_RELOAD_OFS  = 12'h008;
    localparam logic [TIMER_OFS_W-1:0] TIMER_INTSTAT_OFS = 12'h00C;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_EXTGATE_BIT = 1;
    localparam int unsigned CTRL_EXTCLK_BIT  = 2;
    localparam int unsigned CTRL_IE_BIT      = 3;

    // Reset values
    localparam logic [CTRL_W-1:0]   CTRL_RST    = 4'h0;
    localparam logic [TIMER_DW-1:0] VALUE_RST   = 32'h0000_0000;
    localparam logic [TIMER_DW-1:0] RELOAD_RST  = 32'h0000_0000;
    localparam logic                INTSTAT_RST = 1'b0;

    // Counter behaviour, derived from EN and VALUE
    typedef enum logic [1:0] {
        CNT_STOPPED   = 2'd0,
        CNT_COUNTING  = 2'd1,
        CNT_RELOADING = 2'd2
    } cnt_state_e;

    // True for offsets that hold a register
    function automatic logic ofs_mapped(input logic [TIMER_OFS_W-1:0] ofs);
        return ofs <= TIMER_INTSTAT_OFS;
    endfunction

endpackage

// File: rtl/apb_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module apb_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage resynchronisation of d into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// Zero-wait-state APB slave: 32-bit reloading down-counter with level interrupt,
// optionally paced (EXTCLK) or gated (EXTGATE) by the asynchronous EXTIN input.
// Build option: define APB_TIMER_SLVERR_EN to report PSLVERR on accesses to
// unmapped offsets; otherwise PSLVERR is tied low.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    input  logic                 EXTIN,
    output logic                 TIMERINT
);

    if (DATAWIDTH != TIMER_DW) begin : g_dw_check
        $error("apb_timer: DATAWIDTH must be 32");
    end

    logic [TIMER_OFS_W-1:0] addr_ofs;
    logic                   wr_en;
    logic                   rd_en;
    logic                   wr_ctrl;
    logic                   wr_value;
    logic                   wr_reload;
    logic                   wr_intstat;

    logic [CTRL_W-1:0]      ctrl_q;
    logic [TIMER_DW-1:0]    value_q;
    logic [TIMER_DW-1:0]    reload_q;
    logic                   intstat_q;

    logic                   ext_sync;
    logic                   ext_dly;
    logic                   tick_c;
    cnt_state_e             cnt_state_c;
    logic [TIMER_DW-1:0]    value_d;
    logic                   int_set_c;
    logic [TIMER_DW-1:0]    rdata_c;
    logic                   unused_paddr;

    assign addr_ofs   = {PADDR[11:2], 2'b00};
    assign wr_en      = PSEL & PENABLE & PWRITE;
    assign rd_en      = PSEL & ~PWRITE;
    assign wr_ctrl    = wr_en & (addr_ofs == TIMER_CTRL_OFS);
    assign wr_value   = wr_en & (addr_ofs == TIMER_VALUE_OFS);
    assign wr_reload  = wr_en & (addr_ofs == TIMER_RELOAD_OFS);
    assign wr_intstat = wr_en & (addr_ofs == TIMER_INTSTAT_OFS);

    // Address bits outside the decoded window are deliberately ignored
    assign unused_paddr = ^{PADDR[ADDRWIDTH-1:12], PADDR[1:0]};

    apb_sync2 #(.WIDTH(1)) u_extin_sync (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .d     (EXTIN),
        .q     (ext_sync)
    );

    // One-cycle delay of the synchronised EXTIN for rising-edge detection
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) ext_dly <= 1'b0;
        else          ext_dly <= ext_sync;
    end

    // Count enable: every cycle or per EXTIN rising edge, optionally gated by EXTIN level
    always_comb begin
        tick_c = ctrl_q[CTRL_EN_BIT];
        if (ctrl_q[CTRL_EXTCLK_BIT])  tick_c = tick_c & ext_sync & ~ext_dly;
        if (ctrl_q[CTRL_EXTGATE_BIT]) tick_c = tick_c & ext_sync;
    end

    // Counter mode implied by EN and VALUE
    always_comb begin
        cnt_state_c = CNT_STOPPED;
        if (ctrl_q[CTRL_EN_BIT]) begin
            cnt_state_c = (value_q == '0) ? CNT_RELOADING : CNT_COUNTING;
        end
    end

    // Next VALUE and interrupt set; a bus write to VALUE overrides the tick
    always_comb begin
        value_d   = value_q;
        int_set_c = 1'b0;
        if (wr_value) begin
            value_d = TIMER_DW'(PWDATA);
        end else if (tick_c) begin
            case (cnt_state_c)
                CNT_RELOADING: value_d = reload_q;
                CNT_COUNTING: begin
                    value_d   = value_q - TIMER_DW'(1);
                    int_set_c = ctrl_q[CTRL_IE_BIT] & (value_q == TIMER_DW'(1));
                end
                default: value_d = value_q;
            endcase
        end
    end

    // Register file; interrupt set takes priority over a software clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q    <= CTRL_RST;
            value_q   <= VALUE_RST;
            reload_q  <= RELOAD_RST;
            intstat_q <= INTSTAT_RST;
        end else begin
            value_q <= value_d;
            if (wr_ctrl)   ctrl_q   <= CTRL_W'(PWDATA);
            if (wr_reload) reload_q <= TIMER_DW'(PWDATA);
            if (int_set_c)                    intstat_q <= 1'b1;
            else if (wr_intstat && PWDATA[0]) intstat_q <= 1'b0;
        end
    end

    // Combinational read mux; zero when not reading or offset unmapped
    always_comb begin
        rdata_c = '0;
        if (rd_en) begin
            case (addr_ofs)
                TIMER_CTRL_OFS:    rdata_c = TIMER_DW'(ctrl_q);
                TIMER_VALUE_OFS:   rdata_c = value_q;
                TIMER_RELOAD_OFS:  rdata_c = reload_q;
                TIMER_INTSTAT_OFS: rdata_c = TIMER_DW'(intstat_q);
                default:           rdata_c = '0;
            endcase
        end
    end

    assign PRDATA   = DATAWIDTH'(rdata_c);
    assign PREADY   = 1'b1;
    assign TIMERINT = intstat_q;

`ifdef APB_TIMER_SLVERR_EN
    assign PSLVERR = PSEL & PENABLE & ~ofs_mapped(addr_ofs);
`else
    assign PSLVERR = 1'b0;
`endif

endmodule
